inv_mix_columns_seq: RTL and testbench
======================================

Name: inv_mix_columns_seq

Overview:
- Column-serial AES (Inv)MixColumns stage. Sits directly downstream of the inverse S-box / SubBytes lookup stage.
- Accepts a full 16-byte state over a valid/ready handshake and processes one 4-byte column per clock.
- Presents the 16-byte result on a held valid/ready output to the next round stage (AddRoundKey).
- MODE selects the inverse (decrypt) or forward (encrypt) matrix at elaboration time.

Parameters:
- MODE, 1, 1 = InvMixColumns matrix {0e,0b,0d,09}; 0 = MixColumns matrix {02,03,01,01}.

Ports:
- sys_clk  in  1  single system clock; all state updates on the rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  state_in holds a valid state.
- in_ready  out  1  block can accept a state this cycle.
- state_in  in  128  input state; byte k = state_in[8k+7:8k]; column c = bytes 4c..4c+3; row r of column c = byte 4c+r.
- out_valid  out  1  state_out holds a valid result.
- out_ready  in  1  consumer accepts state_out this cycle.
- state_out  out  128  result state, same byte mapping as state_in.
- busy  out  1  high in CALC.

Behaviour:
- Reset (sys_rst low, asynchronous) sets FSM = IDLE, col = 0, out_valid = 0, busy = 0, working register = 0, state_out = 0.
- Reset asserted mid-CALC aborts the transaction; no output is produced.
- FSM states: IDLE, CALC, DONE.
- in_ready = (IDLE) or (DONE and out_ready). It is combinational from state and out_ready only, never from in_valid.
- Accept occurs on a rising edge where in_valid and in_ready are both high:
  - state_in is captured into the working register.
  - col is set to 0.
  - FSM goes to CALC.
- CALC, one column per clock:
  - Column col of the working register is replaced by its transformed column.
  - col increments by 1.
  - On the edge where col = 3: col wraps to 0, state_out is loaded with the complete result, out_valid goes to 1, FSM goes to DONE.
- DONE:
  - out_valid stays 1 and state_out is held stable until out_ready is 1.
  - out_ready = 1 with in_valid = 0: out_valid goes to 0, FSM goes to IDLE.
  - out_ready = 1 with in_valid = 1: the result is consumed and the new state is accepted on the same edge. out_valid goes to 0 and FSM goes directly to CALC (back-to-back operation, no IDLE bubble).
- state_out changes only on entry to DONE; it holds the last result at all other times.
- Latency: accept edge to out_valid high is 4 clocks.
- Maximum throughput: 1 state per 5 clocks.
- in_valid while in CALC is ignored; in_ready is low and the upstream stage holds its data.
- Arithmetic, all GF(2^8) with modulus x^8+x^4+x^3+x+1:
  - xtime(b) = {b[6:0],0} XOR (b[7] ? 8'h1b : 0).
  - Multiplies by 09/0b/0d/0e are built from chained xtime and XOR. No lookup tables and no multipliers are used.
- Column transform, input column a0..a3, output b0..b3, indices mod 4:
  - MODE = 1: b_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3).
  - MODE = 0: b_r = 02*a_r ^ 03*a_(r+1) ^ a_(r+2) ^ a_(r+3).
- One column datapath instance is shared, selected by col. There is no combinational path from state_in to state_out.

Test Plan:
- Reset, then idle: after sys_rst deasserts, in_ready = 1, out_valid = 0, state_out = 0, busy = 0.
- MODE = 1, single state: columns 8e4da1bc, 9fdc589d, 01010101, d5d5d7d6, presented as byte0..3 per column. Required: out_valid rises exactly 4 clocks after the accept edge; columns = db135345, f20a225c, 01010101, d4d4d4d5; busy is high for exactly 4 clocks.
- MODE = 0, FIPS-197 round-1 state: columns d4bf5d30, e0b452ae, b84111f1, 1e2798e5. Required: 046681e5, e0cb199a, 48f8d37a, 2806264c.
- Backpressure: hold out_ready = 0 for 10 clocks after out_valid. Required: state_out stable, out_valid stays 1, in_ready = 0, and a new in_valid is not accepted. Raising out_ready then gives one transfer and out_valid falls.
- Back-to-back: in_valid held high with two states and out_ready = 1. Required: the second accept happens on the same edge the first result is consumed; results arrive 5 clocks apart and in order.
- Reset mid-CALC: assert sys_rst 2 clocks after accept. Required: out_valid stays 0 and FSM is IDLE after release. The next state is processed correctly, starting from column 0.

Source files
------------

// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES (Inv)MixColumns stage: one 4-byte column per clock,
// 16-byte state in and out over valid/ready handshakes.
module inv_mix_columns_seq #(
   parameter int MODE = 1
) (
   input  logic         sys_clk,
   input  logic         sys_rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [1:0]   r_col;
   logic [127:0] r_work;
   logic [127:0] r_out;
   logic [127:0] w_work_nxt;
   logic [31:0]  w_col_in;
   logic [31:0]  w_col_out;
   logic         w_accept;
   logic         w_last;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [7:0] w_a  [4];
   logic [7:0] w_x2 [4];
   logic [7:0] w_b  [4];

   for (genvar r = 0; r < 4; r++) begin : g_byte
      assign w_a[r]  = w_col_in[8*r +: 8];
      assign w_x2[r] = xt(w_a[r]);
      assign w_col_out[8*r +: 8] = w_b[r];
   end

   if (MODE == 1) begin : g_inv
      logic [7:0] w_x4 [4];
      logic [7:0] w_x8 [4];
      logic [7:0] w_m9 [4];
      logic [7:0] w_mb [4];
      logic [7:0] w_md [4];
      logic [7:0] w_me [4];
      for (genvar r = 0; r < 4; r++) begin : g_mul
         assign w_x4[r] = xt(w_x2[r]);
         assign w_x8[r] = xt(w_x4[r]);
         assign w_m9[r] = w_x8[r] ^ w_a[r];
         assign w_mb[r] = w_x8[r] ^ w_x2[r] ^ w_a[r];
         assign w_md[r] = w_x8[r] ^ w_x4[r] ^ w_a[r];
         assign w_me[r] = w_x8[r] ^ w_x4[r] ^ w_x2[r];
      end
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign w_b[r] = w_me[r]
                       ^ w_mb[(r+1)%4]
                       ^ w_md[(r+2)%4]
                       ^ w_m9[(r+3)%4];
      end
   end else begin : g_fwd
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign w_b[r] = w_x2[r]
                       ^ w_x2[(r+1)%4] ^ w_a[(r+1)%4]
                       ^ w_a[(r+2)%4]
                       ^ w_a[(r+3)%4];
      end
   end

   // single shared column datapath, steered by r_col
   always_comb begin
      w_col_in   = r_work[{r_col, 5'b0} +: 32];
      w_work_nxt = r_work;
      w_work_nxt[{r_col, 5'b0} +: 32] = w_col_out;
   end

   assign in_ready  = (r_state == S_IDLE)
                    | ((r_state == S_DONE) & out_ready);
   assign w_accept  = in_valid & in_ready;
   assign w_last    = (r_state == S_CALC) & (r_col == 2'd3);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_CALC);
   assign state_out = r_out;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_CALC;
         S_CALC: if (r_col == 2'd3) w_state_nxt = S_DONE;
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = in_valid ? S_CALC : S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         r_state <= S_IDLE;
         r_col   <= 2'd0;
         r_work  <= '0;
         r_out   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_work <= state_in;
            r_col  <= 2'd0;
         end else if (r_state == S_CALC) begin
            r_work <= w_work_nxt;
            r_col  <= r_col + 2'd1;
         end
         if (w_last) begin
            r_out <= w_work_nxt;
         end
      end
   end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq: scoreboard queues per instance,
// immediate assertions at every comparison point.
module tb_inv_mix_columns_seq;

   logic         clk;
   logic         rst_n;
   logic         iv1, ir1, ov1, or1, bz1;
   logic [127:0] si1, so1;
   logic         iv0, ir0, ov0, or0, bz0;
   logic [127:0] si0, so0;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [127:0] q1[$];
   logic [127:0] q0[$];
   int           xfer1[$];

   inv_mix_columns_seq #(.MODE(1)) dut (
      .sys_clk(clk), .sys_rst(rst_n),
      .in_valid(iv1), .in_ready(ir1), .state_in(si1),
      .out_valid(ov1), .out_ready(or1), .state_out(so1),
      .busy(bz1)
   );

   inv_mix_columns_seq #(.MODE(0)) dut0 (
      .sys_clk(clk), .sys_rst(rst_n),
      .in_valid(iv0), .in_ready(ir0), .state_in(si0),
      .out_valid(ov0), .out_ready(or0), .state_out(so0),
      .busy(bz0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [127:0] mixs(input logic [127:0] s,
                                         input bit inv);
      logic [7:0]   m [4];
      logic [127:0] o = '0;
      logic [7:0]   acc;
      if (inv) begin
         m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
      end else begin
         m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
               acc = acc ^ gmul(m[j], s[32*c + 8*((r+j)%4) +: 8]);
            end
            o[32*c + 8*r +: 8] = acc;
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] br(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic logic [127:0] cols(input logic [31:0] c0,
      input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3);
      return {br(c3), br(c2), br(c1), br(c0)};
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   always @(negedge clk) begin
      if (rst_n && ov1 && or1) begin
         if (q1.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_out1 observed=%h expected=none", so1);
         end else begin
            chk("out1", so1, q1.pop_front());
         end
         xfer1.push_back(cyc);
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov0 && or0) begin
         if (q0.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_out0 observed=%h expected=none", so0);
         end else begin
            chk("out0", so0, q0.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain1(input string tag);
      for (int i = 0; i < 40 && q1.size() != 0; i++) @(posedge clk);
      #1;
      chk(tag, q1.size(), 0);
   endtask

   logic [127:0] s, held;
   int           nb, first, found, n;

   initial begin
      rst_n = 1'b0;
      iv1 = 1'b0; or1 = 1'b1; si1 = '0;
      iv0 = 1'b0; or0 = 1'b1; si0 = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", ir1, 1'b1);
      chk("rst_out_valid", ov1, 1'b0);
      chk("rst_state_out", so1, '0);
      chk("rst_busy", bz1, 1'b0);
      chk("rst0_in_ready", ir0, 1'b1);
      chk("rst0_out_valid", ov0, 1'b0);
      chk("rst0_state_out", so0, '0);

      // inverse matrix, known vector, latency and busy width
      tick();
      iv1 = 1'b1;
      si1 = cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6);
      q1.push_back(cols(32'hdb135345, 32'hf20a225c,
                        32'h01010101, 32'hd4d4d4d5));
      @(posedge clk);
      #1 iv1 = 1'b0;
      nb = 0;
      first = -1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bz1) nb++;
         if (ov1 && first < 0) first = k;
         @(posedge clk);
      end
      #1;
      chk("latency", first, 4);
      chk("busy_len", nb, 4);
      drain1("drain_vec1");

      // forward matrix, FIPS-197 round-1 column values
      tick();
      iv0 = 1'b1;
      si0 = cols(32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5);
      q0.push_back(cols(32'h046681e5, 32'he0cb199a,
                        32'h48f8d37a, 32'h2806264c));
      @(posedge clk);
      #1 iv0 = 1'b0;
      for (int i = 0; i < 20 && q0.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain_vec0", q0.size(), 0);

      // backpressure
      tick();
      or1 = 1'b0;
      iv1 = 1'b1;
      s = rnd128();
      si1 = s;
      q1.push_back(mixs(s, 1'b1));
      @(posedge clk);
      #1 iv1 = 1'b0;
      for (int i = 0; i < 20 && !ov1; i++) @(negedge clk);
      chk("bp_valid_up", ov1, 1'b1);
      held = so1;
      @(posedge clk);
      #1;
      iv1 = 1'b1;
      s = rnd128();
      si1 = s;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_hold_data", so1, held);
         chk("bp_hold_valid", ov1, 1'b1);
         chk("bp_in_ready", ir1, 1'b0);
         chk("bp_no_accept", bz1, 1'b0);
      end
      @(posedge clk);
      #1;
      q1.push_back(mixs(s, 1'b1));
      or1 = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", ir1, 1'b1);
      @(posedge clk);
      #1 iv1 = 1'b0;
      @(negedge clk);
      chk("bp_valid_fall", ov1, 1'b0);
      chk("bp_next_busy", bz1, 1'b1);
      chk("bp_one_xfer", q1.size(), 1);
      drain1("drain_bp");

      // back-to-back
      tick();
      iv1 = 1'b1;
      s = rnd128();
      si1 = s;
      q1.push_back(mixs(s, 1'b1));
      @(posedge clk);
      #1;
      s = rnd128();
      si1 = s;
      q1.push_back(mixs(s, 1'b1));
      found = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ir1) begin
            found = 1;
            break;
         end
      end
      chk("b2b_found", found, 1);
      chk("b2b_same_edge", ov1, 1'b1);
      @(posedge clk);
      #1 iv1 = 1'b0;
      drain1("drain_b2b");
      n = xfer1.size();
      chk("b2b_spacing", xfer1[n-1] - xfer1[n-2], 5);

      // reset mid-calculation
      tick();
      iv1 = 1'b1;
      si1 = rnd128();
      @(posedge clk);
      #1 iv1 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("abort_valid", ov1, 1'b0);
      chk("abort_busy", bz1, 1'b0);
      chk("abort_state_out", so1, '0);
      repeat (2) tick();
      rst_n = 1'b1;
      n = xfer1.size();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("abort_no_out", ov1, 1'b0);
      end
      chk("abort_idle", ir1, 1'b1);
      chk("abort_xfers", xfer1.size(), n);
      tick();
      iv1 = 1'b1;
      s = rnd128();
      si1 = s;
      q1.push_back(mixs(s, 1'b1));
      @(posedge clk);
      #1 iv1 = 1'b0;
      drain1("drain_after_abort");

      // a few more random states through the inverse instance
      for (int t = 0; t < 4; t++) begin
         tick();
         iv1 = 1'b1;
         s = rnd128();
         si1 = s;
         q1.push_back(mixs(s, 1'b1));
         @(posedge clk);
         #1 iv1 = 1'b0;
         drain1("drain_rand");
      end

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
